// File: rtl/pc_sequencer_pkg.sv
// Shared types and shipped branch-target tables for the program-counter sequencer.
// PC_RELATIVE_EN selects which table the LUT serves: absolute addresses or signed offsets.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } pc_state_t;

    localparam int PC_W_DEF  = 10;
    localparam int LUT_W_DEF = 5;
    localparam int LUT_DEPTH = 32;
    localparam int LUT_IDX_W = $clog2(LUT_DEPTH);

    // Entries are stored 16 bits wide and signed so the relative table sign-extends cleanly.
    localparam logic signed [15:0] PC_LUT_ABS [LUT_DEPTH] = '{
        16'd0,   16'd8,   16'd16,  16'd40,  16'd48,  16'd64,  16'd80,  16'd96,
        16'd112, 16'd128, 16'd144, 16'd160, 16'd176, 16'd192, 16'd208, 16'd224,
        16'd256, 16'd288, 16'd320, 16'd352, 16'd384, 16'd416, 16'd448, 16'd480,
        16'd512, 16'd576, 16'd640, 16'd704, 16'd768, 16'd832, 16'd896, 16'd1023
    };

    localparam logic signed [15:0] PC_LUT_REL [LUT_DEPTH] = '{
        16'h0000, 16'h0001, 16'h0002, 16'hFFFC, 16'h0004, 16'hFFF8, 16'h0008, 16'hFFF0,
        16'h0010, 16'hFFE0, 16'h0020, 16'hFFC0, 16'h0040, 16'hFF80, 16'h0080, 16'hFFFE,
        16'h0003, 16'hFFFD, 16'h0005, 16'hFFFB, 16'h0006, 16'hFFFA, 16'h0007, 16'hFFF9,
        16'h000A, 16'hFFF6, 16'h000C, 16'hFFF4, 16'h0014, 16'hFFEC, 16'h0064, 16'hFF9C
    };

`ifdef PC_RELATIVE_EN
    localparam logic signed [15:0] PC_LUT [LUT_DEPTH] = PC_LUT_REL;
`else
    localparam logic signed [15:0] PC_LUT [LUT_DEPTH] = PC_LUT_ABS;
`endif

endpackage

// File: rtl/pc_sequencer_lut.sv
// Combinational branch-target ROM: maps a LUT index to a PC_W-bit table entry.
// The entry is an absolute address or a signed offset depending on PC_RELATIVE_EN.
module pc_lut
    import pc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int LUT_W = LUT_W_DEF
) (
    input  logic [LUT_W-1:0] Target,
    output logic [PC_W-1:0]  entry
);

    logic [LUT_IDX_W-1:0] idx;

    assign idx = LUT_IDX_W'(Target);

    // Signed cast keeps offsets correct if PC_W is ever wider than the stored entries.
    assign entry = PC_W'(PC_LUT[idx]);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/prime/run/halt FSM plus hold/increment/branch next-PC select.
// With PC_RELATIVE_EN defined, branch targets are PC plus a signed LUT offset.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int LUT_W      = LUT_W_DEF,
    parameter int START_ADDR = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             taken,
    input  logic             Branch,
    input  logic             Jump,
    input  logic [LUT_W-1:0] Target,
    input  logic             Halt,
    input  logic             Hold,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done
);

    // Harness handshake: Start is a level; holding it primes the PC, its release begins
    // execution, and Done stays high from the halt until the next Start is seen.
    pc_state_t state;

    logic [PC_W-1:0] lut_entry;
    logic [PC_W-1:0] target_pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] start_pc;
    logic            take_target;

    pc_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_lut (
        .Target (Target),
        .entry  (lut_entry)
    );

`ifdef PC_RELATIVE_EN
    assign target_pc = ProgCtr + lut_entry;
`else
    assign target_pc = lut_entry;
`endif

    assign pc_inc      = ProgCtr + PC_W'(1);
    assign start_pc    = PC_W'(START_ADDR);
    assign take_target = Jump || (Branch && taken);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Running <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state   <= PRIME;
                        ProgCtr <= start_pc;
                    end
                end
                PRIME: begin
                    ProgCtr <= start_pc;
                    if (!Start) begin
                        state   <= RUN;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (Start) begin
                        state   <= PRIME;
                        ProgCtr <= start_pc;
                        Running <= 1'b0;
                    end else if (Halt) begin
                        // PC stays on the halt instruction so the harness can see where it stopped.
                        state   <= HALTED;
                        Running <= 1'b0;
                        Done    <= 1'b1;
                    end else if (!Hold) begin
                        if (take_target) begin
                            ProgCtr <= target_pc;
                        end else begin
                            ProgCtr <= pc_inc;
                        end
                    end
                end
                HALTED: begin
                    if (Start) begin
                        state   <= PRIME;
                        ProgCtr <= start_pc;
                        Done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ProgCtr <= '0;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver pushes expected {ProgCtr, Running, Done} per edge,
// a monitor pops and compares on the falling edge.
module tb_pc_sequencer;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       taken;
    logic       Branch;
    logic       Jump;
    logic [4:0] Target;
    logic       Halt;
    logic       Hold;
    logic [9:0] ProgCtr;
    logic       Running;
    logic       Done;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          step_idx = 0;

    pc_sequencer dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .taken   (taken),
        .Branch  (Branch),
        .Jump    (Jump),
        .Target  (Target),
        .Halt    (Halt),
        .Hold    (Hold),
        .ProgCtr (ProgCtr),
        .Running (Running),
        .Done    (Done)
    );

    // Clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got pc=%0d running=%0b done=%0b, expected pc=%0d running=%0b done=%0b",
                     name, act[11:2], act[1], act[0], exp[11:2], exp[1], exp[0]);
        end
    endtask

    // Driver: apply inputs, then after the sampling edge queue the expected outputs.
    task automatic cyc(input logic st, input logic br, input logic tk, input logic jp,
                       input logic [4:0] tg, input logic hl, input logic hd,
                       input logic [9:0] epc, input logic er, input logic ed);
        Start  = st;
        Branch = br;
        taken  = tk;
        Jump   = jp;
        Target = tg;
        Halt   = hl;
        Hold   = hd;
        @(posedge Clk);
        exp_q.push_back({epc, er, ed});
        #1;
    endtask

    task automatic run_step(input logic [9:0] epc);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, epc, 1'b1, 1'b0);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("step%0d", step_idx), {ProgCtr, Running, Done}, e);
                step_idx++;
            end
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; taken = 1'b0; Branch = 1'b0; Jump = 1'b0;
        Target = 5'd0; Halt = 1'b0; Hold = 1'b0;
        #12;
        check("reset_values", {ProgCtr, Running, Done}, 12'd0);
        Reset = 1'b0;

        // Prime for three cycles, then release
        cyc(1, 0, 0, 0, 5'd0, 0, 0, 10'd0, 0, 0);
        cyc(1, 0, 0, 0, 5'd0, 0, 0, 10'd0, 0, 0);
        cyc(1, 0, 0, 0, 5'd0, 0, 0, 10'd0, 0, 0);
        cyc(0, 0, 0, 0, 5'd0, 0, 0, 10'd0, 1, 0);
        run_step(10'd1);
        run_step(10'd2);
        run_step(10'd3);
        run_step(10'd4);
        run_step(10'd5);

        // Hold two cycles at 5, then advance; jump under hold stays put
        cyc(0, 0, 0, 0, 5'd0, 0, 1, 10'd5, 1, 0);
        cyc(0, 0, 0, 0, 5'd0, 0, 1, 10'd5, 1, 0);
        run_step(10'd6);
        cyc(0, 0, 0, 1, 5'd3, 0, 1, 10'd6, 1, 0);
        run_step(10'd7);

        // Not-taken branch, then taken branch to index 3
        cyc(0, 1, 0, 0, 5'd3, 0, 0, 10'd8, 1, 0);
`ifdef PC_RELATIVE_EN
        cyc(0, 1, 1, 0, 5'd3, 0, 0, 10'd4, 1, 0);
        run_step(10'd5);
        cyc(0, 1, 0, 1, 5'd3, 0, 0, 10'd1, 1, 0);
        run_step(10'd2);
        cyc(0, 0, 0, 1, 5'd3, 0, 0, 10'd1022, 1, 0);
        run_step(10'd1023);
        run_step(10'd0);
`else
        cyc(0, 1, 1, 0, 5'd3, 0, 0, 10'd40, 1, 0);
        cyc(0, 1, 0, 1, 5'd3, 0, 0, 10'd40, 1, 0);
        cyc(0, 0, 0, 1, 5'd31, 0, 0, 10'd1023, 1, 0);
        run_step(10'd0);
`endif

        // Count up to 12 and halt there
        for (int i = 1; i <= 12; i++) run_step(10'(i));
        cyc(0, 0, 0, 0, 5'd0, 1, 0, 10'd12, 0, 1);
        cyc(0, 1, 1, 1, 5'd3, 0, 0, 10'd12, 0, 1);
        cyc(1, 0, 0, 0, 5'd0, 0, 0, 10'd0, 0, 0);
        cyc(0, 0, 0, 0, 5'd0, 0, 0, 10'd0, 1, 0);
        for (int i = 1; i <= 20; i++) run_step(10'(i));

        // Asynchronous reset between clock edges at PC=20
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        check("async_reset", {ProgCtr, Running, Done}, 12'd0);
        @(posedge Clk);
        #3;
        Reset = 1'b0;

        // Decoder strobes in IDLE have no effect
        cyc(0, 1, 1, 1, 5'd3, 0, 0, 10'd0, 0, 0);
        cyc(0, 0, 0, 1, 5'd31, 1, 0, 10'd0, 0, 0);

        // One-cycle Start pulse still primes for one cycle
        cyc(1, 0, 0, 0, 5'd0, 0, 0, 10'd0, 0, 0);
        cyc(0, 0, 0, 0, 5'd0, 0, 0, 10'd0, 1, 0);
        run_step(10'd1);
        run_step(10'd2);

        repeat (2) @(posedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d pending entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
